// File: rtl/io_edge_monitor.sv
// ---------------------------------------------------------------------------
// io_edge_monitor
//
// Purpose:
//   Watches one already-synchronised pin sample and measures its activity
//   over a start/stop window. It counts rising and falling edges, records
//   the shortest and longest complete high and low pulses, and counts the
//   cycles spent measuring.
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-high reset
//   in            synchronised pin samples from the I/O stage (COUNT bits)
//   sel           index of the pin to monitor, latched on an accepted start
//   start         single-cycle pulse: clear results and begin measuring
//   stop          single-cycle pulse: end measurement and hold results
//   active        high while arming or running
//   rise_count    rising edges seen
//   fall_count    falling edges seen
//   min_high      shortest complete high pulse (all-ones while no complete pulse is recorded)
//   max_high      longest complete high pulse
//   min_low       shortest complete low pulse (all-ones while no complete pulse is recorded)
//   max_low       longest complete low pulse
//   total_cycles  measuring cycles elapsed
//
// Build option:
//   IO_EDGE_MONITOR_GLITCH_FILTER_EN - when defined, the monitored sample
//   passes through a deglitcher that only follows a new level after it has
//   been held for 3 consecutive cycles.
// ---------------------------------------------------------------------------
module io_edge_monitor #(
    parameter int COUNT     = 1,
    parameter int SEL_BITS  = 8,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [COUNT-1:0]     in,
    input  logic [SEL_BITS-1:0]  sel,
    input  logic                 start,
    input  logic                 stop,
    output logic                 active,
    output logic [CNT_WIDTH-1:0] rise_count,
    output logic [CNT_WIDTH-1:0] fall_count,
    output logic [CNT_WIDTH-1:0] min_high,
    output logic [CNT_WIDTH-1:0] max_high,
    output logic [CNT_WIDTH-1:0] min_low,
    output logic [CNT_WIDTH-1:0] max_low,
    output logic [CNT_WIDTH-1:0] total_cycles
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] ALL_ONES = '1;
    localparam logic [CNT_WIDTH-1:0] ONE      = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                state;
    state_t                state_next;
    logic                  start_accept;
    logic [SEL_BITS-1:0]   sel_q;
    logic                  raw_bit;
    logic                  cur;
    logic                  prev;
    logic                  seen_edge;
    logic [CNT_WIDTH-1:0]  run_len;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] x);
        return (x == ALL_ONES) ? x : x + ONE;
    endfunction

    // State register for the IDLE/ARM/RUN controller.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A start is only honoured in IDLE or RUN, since ARM
    // always moves on to RUN after its single preload cycle. In RUN, start
    // is checked before stop so a simultaneous pair restarts the window.
    always_comb begin
        state_next   = state;
        start_accept = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next   = ARM;
                    start_accept = 1'b1;
                end
            end
            ARM: begin
                state_next = RUN;
            end
            RUN: begin
                if (start) begin
                    state_next   = ARM;
                    start_accept = 1'b1;
                end else if (stop) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign active = (state != IDLE);

    // Pin selection. An index beyond the vector reads as a constant 0, so
    // nothing is ever recorded for an out-of-range selection.
    always_comb begin
        raw_bit = 1'b0;
        for (int i = 0; i < COUNT; i++) begin
            if (sel_q == SEL_BITS'(i)) begin
                raw_bit = in[i];
            end
        end
    end

`ifdef IO_EDGE_MONITOR_GLITCH_FILTER_EN
    logic       filt_q;
    logic [1:0] hold_cnt;

    // Deglitcher. hold_cnt counts consecutive samples that differ from the
    // filtered level; on the third such sample the new level is passed
    // straight through to cur, so a held level arrives two cycles late and
    // pulse widths of 3 or more cycles are preserved.
    assign cur = (hold_cnt == 2'd2 && raw_bit != filt_q) ? raw_bit : filt_q;

    // Filter state: preloaded with the raw sample while arming, then
    // tracks the raw sample only while running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q   <= 1'b0;
            hold_cnt <= 2'd0;
        end else if (state == ARM) begin
            filt_q   <= raw_bit;
            hold_cnt <= 2'd0;
        end else if (state == RUN) begin
            if (raw_bit == filt_q) begin
                hold_cnt <= 2'd0;
            end else if (hold_cnt == 2'd2) begin
                filt_q   <= raw_bit;
                hold_cnt <= 2'd0;
            end else begin
                hold_cnt <= hold_cnt + 2'd1;
            end
        end
    end
`else
    assign cur = raw_bit;
`endif

    // Measurement datapath. An accepted start clears everything and takes
    // priority over the RUN update of that same cycle. ARM seeds the
    // comparison level and the first (partial) run length. In RUN every
    // level change closes the current run; it is only recorded as a pulse
    // once a previous edge has been seen, which drops the partial segment
    // that started before arming.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q        <= '0;
            prev         <= 1'b0;
            seen_edge    <= 1'b0;
            run_len      <= '0;
            rise_count   <= '0;
            fall_count   <= '0;
            min_high     <= ALL_ONES;
            max_high     <= '0;
            min_low      <= ALL_ONES;
            max_low      <= '0;
            total_cycles <= '0;
        end else if (start_accept) begin
            sel_q        <= sel;
            seen_edge    <= 1'b0;
            rise_count   <= '0;
            fall_count   <= '0;
            min_high     <= ALL_ONES;
            max_high     <= '0;
            min_low      <= ALL_ONES;
            max_low      <= '0;
            total_cycles <= '0;
        end else if (state == ARM) begin
            prev    <= raw_bit;
            run_len <= ONE;
        end else if (state == RUN) begin
            total_cycles <= sat_inc(total_cycles);
            prev         <= cur;
            if (cur == prev) begin
                run_len <= sat_inc(run_len);
            end else begin
                if (cur) begin
                    rise_count <= sat_inc(rise_count);
                end else begin
                    fall_count <= sat_inc(fall_count);
                end
                if (seen_edge) begin
                    if (prev) begin
                        if (run_len < min_high) min_high <= run_len;
                        if (run_len > max_high) max_high <= run_len;
                    end else begin
                        if (run_len < min_low) min_low <= run_len;
                        if (run_len > max_low) max_low <= run_len;
                    end
                end
                run_len   <= ONE;
                seen_edge <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_io_edge_monitor.sv
// ---------------------------------------------------------------------------
// tb_io_edge_monitor
//
// Drives two monitors from the same stimulus: a wide one (32-bit counters)
// and a narrow one (4-bit counters) to exercise saturation. Each measurement
// window is described by a list of pin vectors: entry 0 is the value seen
// while arming, entries 1..N are sampled on the N running edges, and stop
// (when used) rides on entry N. The reference model turns the selected bit
// stream into a list of constant-level segments and derives every result
// from that list.
// ---------------------------------------------------------------------------
module tb_io_edge_monitor;

    localparam int NPINS = 4;

    typedef struct {
        longint rise;
        longint fall;
        longint minh;
        longint maxh;
        longint minl;
        longint maxl;
        longint total;
    } res_t;

    logic             clk;
    logic             rst;
    logic [NPINS-1:0] in_v;
    logic [7:0]       sel;
    logic             start;
    logic             stop;

    logic        active,     active_s;
    logic [31:0] rise_count, fall_count, min_high, max_high, min_low, max_low, total_cycles;
    logic [3:0]  rise_s, fall_s, minh_s, maxh_s, minl_s, maxl_s, total_s;

    int checks = 0;
    int errors = 0;

    logic [NPINS-1:0] pat[$];
    bit               vseq[$];
    logic [7:0]       cur_sel;

    io_edge_monitor #(.COUNT(NPINS), .SEL_BITS(8), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in(in_v), .sel(sel), .start(start), .stop(stop),
        .active(active), .rise_count(rise_count), .fall_count(fall_count),
        .min_high(min_high), .max_high(max_high), .min_low(min_low),
        .max_low(max_low), .total_cycles(total_cycles)
    );

    io_edge_monitor #(.COUNT(NPINS), .SEL_BITS(8), .CNT_WIDTH(4)) dut_s (
        .clk(clk), .rst(rst), .in(in_v), .sel(sel), .start(start), .stop(stop),
        .active(active_s), .rise_count(rise_s), .fall_count(fall_s),
        .min_high(minh_s), .max_high(maxh_s), .min_low(minl_s),
        .max_low(maxl_s), .total_cycles(total_s)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and settle just after it.
    task tick();
        @(posedge clk);
        #1;
    endtask

    // Single comparison point.
    task checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Append len vectors whose bit selbit is level; other pins are random.
    task push_seg(input bit level, input int len, input int selbit);
        logic [NPINS-1:0] v;
        for (int i = 0; i < len; i++) begin
            v = NPINS'($urandom);
            if (selbit < NPINS) v[selbit] = level;
            pat.push_back(v);
        end
    endtask

    // Build a random pulse train on selbit.
    task random_pattern(input int selbit);
        bit lvl;
        int nseg;
        pat.delete();
        lvl  = 1'($urandom);
        nseg = $urandom_range(3, 8);
        for (int i = 0; i < nseg; i++) begin
            push_seg(lvl, $urandom_range(1, 20), selbit);
            lvl = ~lvl;
        end
        push_seg(lvl, 1, selbit);
    endtask

    // Run one measurement window over pat.
    task applyStimulus(input logic [7:0] s, input bit stop_with_start, input bit end_with_stop,
                       input bit arm_stop);
        cur_sel = s;
        sel     = s;
        start   = 1'b1;
        stop    = stop_with_start;
        in_v    = pat[0];
        tick();
        checkOutput("start active", {63'd0, active}, 64'd1);
        checkOutput("start rise cleared", {32'd0, rise_count}, 64'd0);
        checkOutput("start total cleared", {32'd0, total_cycles}, 64'd0);
        checkOutput("start min_high set", {32'd0, min_high}, 64'hFFFF_FFFF);
        checkOutput("start max_low cleared", {32'd0, max_low}, 64'd0);
        checkOutput("start narrow min_low set", {60'd0, minl_s}, 64'd15);
        start = 1'b0;
        stop  = arm_stop;
        sel   = 8'($urandom);
        tick();
        if (arm_stop) checkOutput("arm stop ignored", {63'd0, active}, 64'd1);
        stop = 1'b0;
        for (int k = 1; k < pat.size(); k++) begin
            in_v = pat[k];
            stop = end_with_stop && (k == pat.size() - 1);
            tick();
        end
        stop = 1'b0;
    endtask

    // Selected bit stream seen by the monitor, optionally deglitched.
    task build_seq();
        bit raw[$];
        bit f;
        raw.delete();
        vseq.delete();
        foreach (pat[k]) raw.push_back((cur_sel < NPINS) ? pat[k][cur_sel[1:0]] : 1'b0);
`ifdef IO_EDGE_MONITOR_GLITCH_FILTER_EN
        f = raw[0];
        vseq.push_back(f);
        for (int k = 1; k < raw.size(); k++) begin
            if (k >= 2 && raw[k] == raw[k-1] && raw[k-1] == raw[k-2] && raw[k] != f) f = raw[k];
            vseq.push_back(f);
        end
`else
        f = 1'b0;
        foreach (raw[k]) vseq.push_back(raw[k]);
`endif
    endtask

    // Reference: split the stream into segments, drop the first and last
    // (partial) segments, and aggregate with saturation at maxv.
    task automatic run_model(input longint maxv, output res_t r);
        bit     lvl[$];
        longint len[$];
        longint n;
        longint seg;
        n       = vseq.size() - 1;
        r.rise  = 0;
        r.fall  = 0;
        r.minh  = maxv;
        r.maxh  = 0;
        r.minl  = maxv;
        r.maxl  = 0;
        r.total = (n > maxv) ? maxv : n;
        seg     = 1;
        for (int k = 1; k <= n; k++) begin
            if (vseq[k] == vseq[k-1]) begin
                seg++;
            end else begin
                if (vseq[k]) r.rise++; else r.fall++;
                lvl.push_back(vseq[k-1]);
                len.push_back(seg);
                seg = 1;
            end
        end
        if (r.rise > maxv) r.rise = maxv;
        if (r.fall > maxv) r.fall = maxv;
        for (int i = 1; i < len.size(); i++) begin
            seg = (len[i] > maxv) ? maxv : len[i];
            if (lvl[i]) begin
                if (seg < r.minh) r.minh = seg;
                if (seg > r.maxh) r.maxh = seg;
            end else begin
                if (seg < r.minl) r.minl = seg;
                if (seg > r.maxl) r.maxl = seg;
            end
        end
    endtask

    // Compare both monitors against the model after a stopped window.
    task automatic check_results(input string tag);
        res_t r32;
        res_t r4;
        build_seq();
        run_model(64'hFFFF_FFFF, r32);
        run_model(15, r4);
        checkOutput({tag, " active"}, {63'd0, active}, 64'd0);
        checkOutput({tag, " rise"}, {32'd0, rise_count}, r32.rise);
        checkOutput({tag, " fall"}, {32'd0, fall_count}, r32.fall);
        checkOutput({tag, " min_high"}, {32'd0, min_high}, r32.minh);
        checkOutput({tag, " max_high"}, {32'd0, max_high}, r32.maxh);
        checkOutput({tag, " min_low"}, {32'd0, min_low}, r32.minl);
        checkOutput({tag, " max_low"}, {32'd0, max_low}, r32.maxl);
        checkOutput({tag, " total"}, {32'd0, total_cycles}, r32.total);
        checkOutput({tag, " narrow active"}, {63'd0, active_s}, 64'd0);
        checkOutput({tag, " narrow rise"}, {60'd0, rise_s}, r4.rise);
        checkOutput({tag, " narrow fall"}, {60'd0, fall_s}, r4.fall);
        checkOutput({tag, " narrow min_high"}, {60'd0, minh_s}, r4.minh);
        checkOutput({tag, " narrow max_high"}, {60'd0, maxh_s}, r4.maxh);
        checkOutput({tag, " narrow min_low"}, {60'd0, minl_s}, r4.minl);
        checkOutput({tag, " narrow max_low"}, {60'd0, maxl_s}, r4.maxl);
        checkOutput({tag, " narrow total"}, {60'd0, total_s}, r4.total);
    endtask

    // Directed sequence of measurement scenarios.
    initial begin
        rst   = 1'b1;
        in_v  = '0;
        sel   = '0;
        start = 1'b0;
        stop  = 1'b0;
        #1;
        checkOutput("reset active", {63'd0, active}, 64'd0);
        checkOutput("reset rise", {32'd0, rise_count}, 64'd0);
        checkOutput("reset max_high", {32'd0, max_high}, 64'd0);
        checkOutput("reset min_low", {32'd0, min_low}, 64'hFFFF_FFFF);
        checkOutput("reset total", {32'd0, total_cycles}, 64'd0);
        #10;
        rst = 1'b0;
        tick();

        $display("[TB] square wave on pin 2");
        pat.delete();
        push_seg(1'b0, 4, 2);
        for (int p = 0; p < 3; p++) begin
            push_seg(1'b1, 5, 2);
            push_seg(1'b0, 3, 2);
        end
        applyStimulus(8'd2, 1'b0, 1'b1, 1'b1);
        check_results("square");
        checkOutput("square rise const", {32'd0, rise_count}, 64'd3);
        checkOutput("square fall const", {32'd0, fall_count}, 64'd3);
        checkOutput("square min_high const", {32'd0, min_high}, 64'd5);
        checkOutput("square max_low const", {32'd0, max_low}, 64'd3);

        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        checkOutput("idle stop active", {63'd0, active}, 64'd0);
        checkOutput("idle stop holds rise", {32'd0, rise_count}, 64'd3);

        $display("[TB] partial segments");
        pat.delete();
        push_seg(1'b1, 7, 1);
        push_seg(1'b0, 2, 1);
        push_seg(1'b1, 1, 1);
        applyStimulus(8'd1, 1'b0, 1'b1, 1'b0);
        check_results("partial");
`ifndef IO_EDGE_MONITOR_GLITCH_FILTER_EN
        checkOutput("partial min_low const", {32'd0, min_low}, 64'd2);
        checkOutput("partial min_high const", {32'd0, min_high}, 64'hFFFF_FFFF);
        checkOutput("partial max_high const", {32'd0, max_high}, 64'd0);
`endif

        $display("[TB] out-of-range selection");
        pat.delete();
        for (int k = 0; k <= 20; k++) pat.push_back((k % 2) ? 4'hF : 4'h0);
        applyStimulus(8'd9, 1'b0, 1'b1, 1'b0);
        check_results("oor");
        checkOutput("oor rise const", {32'd0, rise_count}, 64'd0);
        checkOutput("oor total const", {32'd0, total_cycles}, 64'd20);

        $display("[TB] saturation");
        pat.delete();
        push_seg(1'b1, 21, 0);
        applyStimulus(8'd0, 1'b0, 1'b1, 1'b0);
        check_results("sat");
        checkOutput("sat narrow total const", {60'd0, total_s}, 64'd15);

        $display("[TB] restart with start and stop together");
        random_pattern(3);
        applyStimulus(8'd3, 1'b0, 1'b0, 1'b0);
        random_pattern(0);
        applyStimulus(8'd0, 1'b1, 1'b1, 1'b0);
        check_results("restart");

        $display("[TB] random windows");
        for (int t = 0; t < 8; t++) begin
            logic [7:0] s;
            s = 8'($urandom_range(0, 5));
            random_pattern(int'(s));
            applyStimulus(s, 1'b0, 1'b1, 1'($urandom));
            check_results($sformatf("rand%0d", t));
        end

`ifdef IO_EDGE_MONITOR_GLITCH_FILTER_EN
        $display("[TB] glitch filter");
        pat.delete();
        push_seg(1'b0, 4, 0);
        push_seg(1'b1, 2, 0);
        push_seg(1'b0, 4, 0);
        push_seg(1'b1, 6, 0);
        push_seg(1'b0, 5, 0);
        applyStimulus(8'd0, 1'b0, 1'b1, 1'b0);
        check_results("glitch");
        checkOutput("glitch rise const", {32'd0, rise_count}, 64'd1);
        checkOutput("glitch max_high const", {32'd0, max_high}, 64'd6);
`endif

        $display("[TB] asynchronous reset mid-run");
        pat.delete();
        push_seg(1'b0, 1, 3);
        push_seg(1'b1, 1, 3);
        push_seg(1'b0, 1, 3);
        push_seg(1'b1, 2, 3);
        applyStimulus(8'd3, 1'b0, 1'b0, 1'b0);
`ifndef IO_EDGE_MONITOR_GLITCH_FILTER_EN
        checkOutput("pre-reset rise", {32'd0, rise_count}, 64'd2);
`endif
        checkOutput("pre-reset active", {63'd0, active}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async reset active", {63'd0, active}, 64'd0);
        checkOutput("async reset rise", {32'd0, rise_count}, 64'd0);
        checkOutput("async reset total", {32'd0, total_cycles}, 64'd0);
        checkOutput("async reset min_high", {32'd0, min_high}, 64'hFFFF_FFFF);
        #3;
        rst = 1'b0;
        tick();
        checkOutput("post-reset idle", {63'd0, active}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_edge_monitor.md
# io_edge_monitor

Measures edge activity and pulse widths on one selected, already-synchronised pin sample. The block sits directly downstream of the pin I/O stage and consumes its registered `in` vector. Under start/stop control it counts rising and falling edges and records the minimum and maximum high and low pulse widths. It also counts the cycles of the measurement window, so test firmware can check signals driven by the device under test.

## Interface
- `COUNT`, 1, width of the sampled pin vector.
- `SEL_BITS`, 8, width of the pin-select index.
- `CNT_WIDTH`, 32, width of every counter and width register.

- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `in`  in  COUNT  synchronised pin samples from the I/O stage.
- `sel`  in  SEL_BITS  index of the pin to monitor; latched on start.
- `start`  in  1  single-cycle pulse: clear results and begin measuring.
- `stop`  in  1  single-cycle pulse: end measurement and hold results.
- `active`  out  1  high while in ARM or RUN.
- `rise_count`  out  CNT_WIDTH  rising edges seen.
- `fall_count`  out  CNT_WIDTH  falling edges seen.
- `min_high`, `max_high`  out  CNT_WIDTH  shortest and longest complete high pulse, in cycles.
- `min_low`, `max_low`  out  CNT_WIDTH  shortest and longest complete low pulse, in cycles.
- `total_cycles`  out  CNT_WIDTH  RUN cycles elapsed.

## Operation
- The state machine has three states: IDLE, ARM and RUN.
- Transitions:
  - IDLE, on `start`: go to ARM.
  - ARM: go to RUN unconditionally.
  - RUN, on `stop`: go to IDLE.
  - RUN, on `start`: go to ARM (restart).
- On every accepted `start`:
  - latch `sel` into `sel_q`;
  - zero all counts and `max_*`;
  - set `min_*` to all-ones;
  - clear `seen_edge`.
- ARM: load `prev <= in[sel_q]`; load `run_len <= 1`.
- RUN, each cycle, with `cur = in[sel_q]`:
  - `total_cycles` increments.
  - If `cur == prev`: `run_len` increments.
  - If `cur != prev`: the edge increments `rise_count` (0→1) or `fall_count` (1→0).
    - If `seen_edge` is set, `run_len` is a complete pulse of level `prev`; update `min_prev`/`max_prev` with it.
    - Then `run_len <= 1` and `seen_edge <= 1`.
  - `prev <= cur`.
- The first segment after arming is partial and is never recorded. A trailing partial segment at `stop` is also not recorded.
- All counters and `run_len` saturate at all-ones and never wrap.
- A `min_*` that is still all-ones after `stop` means no complete pulse of that level was seen.
- If `sel_q >= COUNT`, `cur` is 0: no edges and no pulses are recorded.
- `start` and `stop` asserted in the same cycle: `start` wins.
- `stop` while in IDLE or ARM:
  - In IDLE it is ignored.
  - In ARM it is ignored, and the block enters RUN.
- Results hold their values in IDLE until the next `start`.

## Timing
- Reset values:
  - state IDLE;
  - `active` 0;
  - all counts and `max_*` 0;
  - `min_*` all-ones;
  - `sel_q` 0.
- `start` sampled at edge T:
  - cleared results are visible after T;
  - ARM occupies cycle T+1;
  - the first RUN compare happens at edge T+2.
- `active` rises after T and falls after the edge that samples `stop`.
- A level change on `in` that is sampled at RUN edge N updates the outputs after edge N, i.e. one-cycle latency from sample to output.
- `total_cycles` equals the number of RUN edges, including the edge that samples `stop`.
- Asynchronous reset mid-RUN returns the block to IDLE immediately with reset values. The measurement is lost.

## Configuration
- `IO_EDGE_MONITOR_GLITCH_FILTER_EN`
  - Defined: `cur` is the output of a deglitcher. The deglitcher changes level only after the raw sample has held the new level for 3 consecutive cycles.
    - Pulses shorter than 3 cycles are not counted.
    - Edge latency grows by 2 cycles.
    - Recorded widths are unchanged for pulses of 3 cycles or more.
    - ARM preloads the filter with the raw sample.
  - Undefined: `cur` is the raw `in[sel_q]`, with no filter logic.

## Test plan
- Square wave:
  - Stimulus: COUNT=4, `sel`=2, `start`, then `in[2]` low 4 cycles, then 3 periods of high 5 / low 3, then `stop`.
  - Expected: `rise_count`=3, `fall_count`=3, `min_high`=`max_high`=5, `min_low`=`max_low`=3.
- Partial segments:
  - Stimulus: `in` high at arm for 7 cycles, falls, low 2, rises, `stop`.
  - Expected: `fall_count`=1, `rise_count`=1, `min_low`=2, `min_high`=all-ones, `max_high`=0.
- Selection out of range:
  - Stimulus: `sel`=9 with COUNT=4; toggle all pins for 20 cycles.
  - Expected: all edge counts 0, `total_cycles`=20.
- Saturation and restart:
  - Stimulus: CNT_WIDTH=4, hold level for 20 RUN cycles.
  - Expected: `total_cycles`=15.
  - Stimulus: `start` together with `stop`.
  - Expected: `active` stays 1 and results clear.
- Reset:
  - Stimulus: assert `rst` asynchronously mid-RUN with `rise_count`=2.
  - Expected: `active`=0 and `rise_count`=0 immediately, without waiting for a clock edge.
- Glitch filter (macro defined):
  - Stimulus: 2-cycle high glitch, then a 6-cycle high pulse.
  - Expected: `rise_count`=1, `max_high`=6.
